// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store sequencer.
// Access sizes, FSM states and the funct3 legality check live here.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        FIN
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_legal_f3(
        input logic [2:0] f3,
        input logic       we
    );
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result extension: picks sign/zero extension from funct3.
// Purely combinational; raw holds the assembled little-endian bytes.
module lsu_load_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = raw;
        case (funct3)
            F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   rdata = {24'h0, raw[7:0]};
            F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   rdata = {16'h0, raw[15:0]};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer: splits RV32 accesses into 2-byte beats on a
// dual-port byte RAM, reassembles loads and holds the pipeline meanwhile.
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [7:0]        ram_wdata_a,
    output logic              ram_we_a,
    input  logic [7:0]        ram_rdata_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [7:0]        ram_wdata_b,
    output logic              ram_we_b,
    input  logic [7:0]        ram_rdata_b
);

    lsu_state_e        state, state_nxt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [15:0]       lo_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic              accept, req_legal, op_legal, fin;
    logic [31:0]       raw, ext;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W];
    assign accept    = req_valid && (state == IDLE);
    assign req_legal = is_legal_f3(req_funct3, req_we);
    assign op_legal  = is_legal_f3(f3_q, we_q);

    always_comb begin
        state_nxt   = state;
        req_ready   = (state == IDLE);
        ram_we_a    = 1'b0;
        ram_we_b    = 1'b0;
        ram_wdata_a = wdata_q[7:0];
        ram_wdata_b = wdata_q[15:8];
        fin         = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) state_nxt = req_legal ? BEAT0 : FIN;
            end
            BEAT0: begin
                ram_we_a  = we_q;
                ram_we_b  = we_q && (f3_q != F3_B);
                state_nxt = (f3_q == F3_W) ? BEAT1 : FIN;
            end
            BEAT1: begin
                ram_we_a    = we_q;
                ram_we_b    = we_q;
                ram_wdata_a = wdata_q[23:16];
                ram_wdata_b = wdata_q[31:24];
                state_nxt   = FIN;
            end
            FIN: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // No RAM write may escape in a reset cycle, even mid-access.
        ram_we_a = ram_we_a && !rst;
        ram_we_b = ram_we_b && !rst;
        fin      = fin && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b0;
            base_q   <= '0;
            wdata_q  <= 32'h0;
            lo_q     <= 16'h0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                base_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
                if (req_legal) begin
                    addr_a_q <= req_addr[ADDR_W-1:0];
                    addr_b_q <= req_addr[ADDR_W-1:0] + ADDR_W'(1);
                end
            end
            if (state == BEAT0 && f3_q == F3_W) begin
                addr_a_q <= base_q + ADDR_W'(2);
                addr_b_q <= base_q + ADDR_W'(3);
            end
            // Read data for the BEAT0 addresses arrives during BEAT1.
            if (state == BEAT1) lo_q <= {ram_rdata_b, ram_rdata_a};
        end
    end

    assign ram_addr_a = addr_a_q;
    assign ram_addr_b = addr_b_q;

    assign raw = (f3_q == F3_W) ? {ram_rdata_b, ram_rdata_a, lo_q}
                                : {16'h0, ram_rdata_b, ram_rdata_a};

    lsu_load_align u_align (
        .funct3 (f3_q),
        .raw    (raw),
        .rdata  (ext)
    );

    assign rsp_valid = fin;
    assign rsp_err   = fin && !op_legal;
    assign rsp_rdata = (fin && op_legal && !we_q) ? ext : 32'h0;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench for dmem_lsu_ctrl with a byte-RAM model attached.
// Expected responses come from a plain-arithmetic reference memory.
module tb_dmem_lsu_ctrl;

    localparam int ADDR_W = 15;
    localparam int MEMSZ  = 32768;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
    logic [7:0]        ram_wdata_a, ram_wdata_b;
    logic              ram_we_a, ram_we_b;
    logic [7:0]        ram_rdata_a, ram_rdata_b;

    logic [7:0]        ram     [0:MEMSZ-1];
    logic [7:0]        ref_mem [0:MEMSZ-1];
    bit                known   [0:MEMSZ-1];

    logic              fill_en;
    logic [ADDR_W-1:0] fill_addr;
    logic [7:0]        fill_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int cyc     = 0;
    int web_cnt = 0;
    int we_cnt  = 0;
    int total   = 0;
    int bad     = 0;
    int coll    = 0;
    int idle_nz = 0;

    dmem_lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ram_addr_a  (ram_addr_a),
        .ram_wdata_a (ram_wdata_a),
        .ram_we_a    (ram_we_a),
        .ram_rdata_a (ram_rdata_a),
        .ram_addr_b  (ram_addr_b),
        .ram_wdata_b (ram_wdata_b),
        .ram_we_b    (ram_we_b),
        .ram_rdata_b (ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we_b) web_cnt <= web_cnt + 1;
        if (ram_we_a || ram_we_b) we_cnt <= we_cnt + 1;
    end

    always @(posedge clk) begin
        if (fill_en) ram[fill_addr] <= fill_data;
        if (ram_we_a) ram[ram_addr_a] <= ram_wdata_a;
        if (ram_we_b) ram[ram_addr_b] <= ram_wdata_b;
        ram_rdata_a <= ram[ram_addr_a];
        ram_rdata_b <= ram[ram_addr_b];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic ck(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr,
                                   input logic [31:0] wdata);
        exp_t   e;
        int     n;
        int     base;
        int     idx;
        longint v;
        bit     legal;
        bit     sgn;
        legal = (f3 <= 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !we);
        if (f3 == 3'd2) n = 4;
        else if (f3 == 3'd1 || f3 == 3'd5) n = 2;
        else n = 1;
        base    = int'(addr % 32'(MEMSZ));
        e.err   = !legal;
        e.rdata = 32'h0;
        e.lat   = !legal ? 0 : (n == 4 ? 2 : 1);
        e.acc   = 0;
        if (legal && we) begin
            for (int k = 0; k < n; k++) begin
                idx = (base + k) % MEMSZ;
                ref_mem[idx] = 8'((wdata >> (8 * k)) & 32'hFF);
                known[idx]   = 1'b1;
            end
        end else if (legal) begin
            v = 0;
            for (int k = 0; k < n; k++) begin
                idx = (base + k) % MEMSZ;
                v = v + (longint'(ref_mem[idx]) << (8 * k));
            end
            sgn = (f3 < 3'd4) && (n < 4);
            if (sgn && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got req_ready=0 want 1");
        end else begin
            e     = model(we, f3, addr, wdata);
            e.acc = cyc + 1;
            sb.push_back(e);
            req_valid  = 1'b1;
            req_we     = we;
            req_funct3 = f3;
            req_addr   = addr;
            req_wdata  = wdata;
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !req_ready) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        fill_en   = 1'b1;
        fill_addr = a;
        fill_data = d;
        @(posedge clk);
        #1;
        fill_en    = 1'b0;
        ref_mem[a] = d;
        known[a]   = 1'b1;
    endtask

    initial begin
        int          snap;
        int          mism;
        logic [31:0] a;
        exp_t        e;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        fill_en    = 1'b0;
        fill_addr  = '0;
        fill_data  = 8'h0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if ((ram_we_a || ram_we_b) && ram_addr_a == ram_addr_b)
                        coll++;
                    if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err))
                        idle_nz++;
                    if (rsp_valid) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_rsp: got rsp_valid=1 want 0");
                        end else begin
                            e = sb.pop_front();
                            ck("rsp_rdata", rsp_rdata, e.rdata);
                            ck("rsp_err", 32'(rsp_err), 32'(e.err));
                            ck("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        ck("rst_ready", 32'(req_ready), 32'd1);
        ck("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        ck("rst_rdata", rsp_rdata, 32'h0);
        ck("rst_err", 32'(rsp_err), 32'd0);
        ck("rst_we", {30'h0, ram_we_a, ram_we_b}, 32'h0);
        ck("rst_addr", 32'({ram_addr_a, ram_addr_b}), 32'h0);
        rst = 1'b0;

        issue(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        drain();
        ck("sw_b0", 32'(ram[15'h0100]), 32'hEF);
        ck("sw_b1", 32'(ram[15'h0101]), 32'hBE);
        ck("sw_b2", 32'(ram[15'h0102]), 32'hAD);
        ck("sw_b3", 32'(ram[15'h0103]), 32'hDE);
        issue(1'b0, 3'd2, 32'h0000_0100, 32'h0);
        issue(1'b0, 3'd0, 32'h0000_0103, 32'h0);
        issue(1'b0, 3'd4, 32'h0000_0103, 32'h0);
        issue(1'b0, 3'd1, 32'h0000_0102, 32'h0);
        issue(1'b0, 3'd5, 32'h0000_0102, 32'h0);
        drain();

        issue(1'b1, 3'd2, 32'h0000_7FFE, 32'h1122_3344);
        drain();
        ck("wrap_7ffe", 32'(ram[15'h7FFE]), 32'h44);
        ck("wrap_7fff", 32'(ram[15'h7FFF]), 32'h33);
        ck("wrap_0000", 32'(ram[15'h0000]), 32'h22);
        ck("wrap_0001", 32'(ram[15'h0001]), 32'h11);
        issue(1'b0, 3'd2, 32'hFFFF_7FFE, 32'h0);
        drain();

        poke(15'h0200, 8'h00);
        poke(15'h0201, 8'h00);
        snap = web_cnt;
        issue(1'b1, 3'd0, 32'h0000_0200, 32'h5A5A_77A5);
        drain();
        ck("sb_0200", 32'(ram[15'h0200]), 32'hA5);
        ck("sb_0201", 32'(ram[15'h0201]), 32'h00);
        ck("sb_web_count", 32'(web_cnt - snap), 32'd0);

        snap = we_cnt;
        issue(1'b0, 3'd3, 32'h0000_0100, 32'h0);
        issue(1'b1, 3'd4, 32'h0000_0100, 32'hFFFF_FFFF);
        issue(1'b1, 3'd7, 32'h0000_0102, 32'hFFFF_FFFF);
        drain();
        ck("illegal_we_count", 32'(we_cnt - snap), 32'd0);

        poke(15'h0302, 8'h5A);
        poke(15'h0303, 8'hC3);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0300;
        req_wdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        ck("rstmid_ready", 32'(req_ready), 32'd1);
        ck("rstmid_rsp", 32'(rsp_valid), 32'd0);
        ref_mem[15'h0300] = 8'h0D;
        known[15'h0300]   = 1'b1;
        ref_mem[15'h0301] = 8'hF0;
        known[15'h0301]   = 1'b1;
        ck("rstmid_0300", 32'(ram[15'h0300]), 32'h0D);
        ck("rstmid_0301", 32'(ram[15'h0301]), 32'hF0);
        ck("rstmid_0302", 32'(ram[15'h0302]), 32'h5A);
        ck("rstmid_0303", 32'(ram[15'h0303]), 32'hC3);

        for (int i = 0; i < 64; i++)
            poke(15'((32'h7FE0 + i) % MEMSZ), 8'($urandom));
        for (int i = 0; i < 60; i++) begin
            a       = $urandom;
            a[14:0] = 15'((32'h7FE0 + $urandom_range(0, 63)) % MEMSZ);
            issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
        end
        drain();
        repeat (2) @(negedge clk);

        mism = 0;
        for (int i = 0; i < MEMSZ; i++)
            if (known[i] && ram[i] !== ref_mem[i]) mism++;
        ck("mem_image_mismatches", 32'(mism), 32'd0);
        ck("port_collisions", 32'(coll), 32'd0);
        ck("rsp_nonzero_idle", 32'(idle_nz), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
